// File: rtl/regfile_pkg.sv
// Shared widths, register address/data types and the hardwired-zero index for the register file.
package regfile_pkg;
  localparam int DFLT_ADDR_WDTH = 5;
  localparam int DFLT_DATA_WDTH = 32;
  localparam int ZERO_REG       = 0;

  typedef logic [DFLT_ADDR_WDTH-1:0] reg_addr_t;
  typedef logic [DFLT_DATA_WDTH-1:0] reg_data_t;
endpackage

// File: rtl/reg_file_sb_if.sv
// Operand-read, issue-claim and writeback bus between the core pipeline and reg_file_sb.
interface reg_file_sb_if
  import regfile_pkg::*;
#(
  parameter int ADDR_WDTH = DFLT_ADDR_WDTH,
  parameter int DATA_WDTH = DFLT_DATA_WDTH,
  parameter int NUM_RD    = 2
);
  logic [NUM_RD*ADDR_WDTH-1:0] rd_addr;
  logic [NUM_RD*DATA_WDTH-1:0] rd_data;
  logic [NUM_RD-1:0]           rd_busy;
  logic                        claim_en;
  logic [ADDR_WDTH-1:0]        claim_addr;
  logic                        claim_ok;
  logic                        we3;
  logic [ADDR_WDTH-1:0]        ad3;
  logic [DATA_WDTH-1:0]        wd3;
  logic [ADDR_WDTH:0]          busy_cnt;
  logic [DATA_WDTH-1:0]        a0;

  modport master (
    output rd_addr, claim_en, claim_addr, we3, ad3, wd3,
    input  rd_data, rd_busy, claim_ok, busy_cnt, a0
  );
  modport slave (
    input  rd_addr, claim_en, claim_addr, we3, ad3, wd3,
    output rd_data, rd_busy, claim_ok, busy_cnt, a0
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one pending-write bit per register, WAW check for claims, running busy count.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WDTH = DFLT_ADDR_WDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      claim_en,
  input  logic [ADDR_WDTH-1:0]      claim_addr,
  input  logic                      we3,
  input  logic [ADDR_WDTH-1:0]      ad3,
  output logic [(1<<ADDR_WDTH)-1:0] busy,
  output logic                      claim_ok,
  output logic [ADDR_WDTH:0]        busy_cnt
);
  localparam int NREG = 1 << ADDR_WDTH;
  localparam int CW   = ADDR_WDTH + 1;

  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_en, set, clr;

  always_comb begin
    wr_en    = we3 && (ad3 != ADDR_WDTH'(ZERO_REG));
    // A writeback landing this cycle frees the slot, so a re-claim is not a WAW.
    claim_ok = !busy_q[claim_addr] || (we3 && (ad3 == claim_addr));
    set      = claim_en && claim_ok && (claim_addr != ADDR_WDTH'(ZERO_REG));
    clr      = wr_en && busy_q[ad3];
    busy_d   = busy_q;
    if (wr_en) busy_d[ad3] = 1'b0;
    if (set)   busy_d[claim_addr] = 1'b1;
    // Same-register set+clear nets to zero; untracked writes never decrement.
    cnt_d    = cnt_q + CW'(set) - CW'(clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;
endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with writeback bypass, hardwired x0 and integrated busy scoreboard.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int ADDR_WDTH = DFLT_ADDR_WDTH,
  parameter int DATA_WDTH = DFLT_DATA_WDTH,
  parameter int NUM_RD    = 2,
  parameter int DBG_REG   = 10
) (
  input logic         clk,
  input logic         rst_n,
  reg_file_sb_if.slave bus
);
  localparam int NREG = 1 << ADDR_WDTH;

  logic [NREG-1:0][DATA_WDTH-1:0]   regs_q, regs_d;
  logic [NREG-1:0]                  busy;
  logic [NUM_RD-1:0][DATA_WDTH-1:0] rd_data_v;
  logic [NUM_RD-1:0]                rd_busy_v;

  always_comb begin
    regs_d = regs_q;
    if (bus.we3 && (bus.ad3 != ADDR_WDTH'(ZERO_REG))) regs_d[bus.ad3] = bus.wd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  reg_scoreboard #(.ADDR_WDTH(ADDR_WDTH)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .claim_en   (bus.claim_en),
    .claim_addr (bus.claim_addr),
    .we3        (bus.we3),
    .ad3        (bus.ad3),
    .busy       (busy),
    .claim_ok   (bus.claim_ok),
    .busy_cnt   (bus.busy_cnt)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WDTH-1:0] ra;
    assign ra = bus.rd_addr[i*ADDR_WDTH +: ADDR_WDTH];

    // A same-cycle writeback both supplies the data and retires the pending claim.
    always_comb begin
      rd_data_v[i] = '0;
      rd_busy_v[i] = 1'b0;
      if (ra == ADDR_WDTH'(ZERO_REG)) begin
        rd_data_v[i] = '0;
      end else if (bus.we3 && (bus.ad3 == ra)) begin
        rd_data_v[i] = bus.wd3;
      end else begin
        rd_data_v[i] = regs_q[ra];
        rd_busy_v[i] = busy[ra];
      end
    end
  end

  assign bus.rd_data = rd_data_v;
  assign bus.rd_busy = rd_busy_v;
  assign bus.a0      = regs_q[DBG_REG];
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed vector table, reset sequences, then random traffic against a reference model.
module tb_reg_file_sb;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  reg_file_sb_if #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .NUM_RD(NR)) rf_if ();

  reg_file_sb #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .NUM_RD(NR), .DBG_REG(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rf_if)
  );

  typedef struct {
    logic        we;
    logic [4:0]  ad;
    logic [31:0] wd;
    logic        ce;
    logic [4:0]  ca;
    logic [4:0]  ra;
    logic [4:0]  ra2;
    logic [31:0] d0;
    logic        b0;
    logic [31:0] d2;
    logic        ok;
    logic [5:0]  cnt;
    logic [31:0] a0;
  } vec_t;

  vec_t tbl[14];

  logic [31:0] mdl_reg [32];
  bit          mdl_busy[32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] ad, input logic [31:0] wd,
                       input logic ce, input logic [4:0] ca,
                       input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
    rf_if.we3        = we;
    rf_if.ad3        = ad;
    rf_if.wd3        = wd;
    rf_if.claim_en   = ce;
    rf_if.claim_addr = ca;
    rf_if.rd_addr    = {r2, r1, r0};
  endtask

  function automatic logic [31:0] port_data(input int p);
    return rf_if.rd_data[p*DW +: DW];
  endfunction

  initial begin
    tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 5'd5,  5'd5,  32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b1, 6'd0, 32'h0};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd5,  5'd0,  32'hDEADBEEF, 1'b0, 32'h0,        1'b1, 6'd0, 32'h0};
    tbl[2]  = '{1'b1, 5'd0,  32'h1234,     1'b0, 5'd0, 5'd0,  5'd0,  32'h0,        1'b0, 32'h0,        1'b1, 6'd0, 32'h0};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 5'd0,  5'd5,  32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 6'd0, 32'h0};
    tbl[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 5'd7,  5'd0,  32'h0,        1'b0, 32'h0,        1'b1, 6'd1, 32'h0};
    tbl[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 5'd7,  5'd7,  32'h0,        1'b1, 32'h0,        1'b0, 6'd1, 32'h0};
    tbl[6]  = '{1'b1, 5'd7,  32'h77,       1'b0, 5'd7, 5'd7,  5'd0,  32'h77,       1'b0, 32'h0,        1'b1, 6'd0, 32'h0};
    tbl[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 5'd7,  5'd0,  32'h77,       1'b0, 32'h0,        1'b1, 6'd1, 32'h0};
    tbl[8]  = '{1'b1, 5'd7,  32'h55,       1'b1, 5'd7, 5'd7,  5'd0,  32'h55,       1'b0, 32'h0,        1'b1, 6'd1, 32'h0};
    tbl[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd7, 5'd7,  5'd5,  32'h55,       1'b1, 32'hDEADBEEF, 1'b0, 6'd1, 32'h0};
    tbl[10] = '{1'b1, 5'd9,  32'h99,       1'b1, 5'd3, 5'd9,  5'd7,  32'h99,       1'b0, 32'h55,       1'b1, 6'd2, 32'h0};
    tbl[11] = '{1'b1, 5'd10, 32'hA5,       1'b0, 5'd3, 5'd3,  5'd10, 32'h0,        1'b1, 32'hA5,       1'b0, 6'd2, 32'hA5};
    tbl[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd10, 5'd10, 32'hA5,       1'b0, 32'hA5,       1'b1, 6'd2, 32'hA5};
    tbl[13] = '{1'b1, 5'd3,  32'h33,       1'b0, 5'd0, 5'd3,  5'd9,  32'h33,       1'b0, 32'h99,       1'b1, 6'd1, 32'hA5};

    // Power-on reset, asserted between edges.
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("reset busy_cnt", 32'(rf_if.busy_cnt), 32'd0);
    chk("reset claim_ok", 32'(rf_if.claim_ok), 32'd1);
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors applied back to back; each row starts where the previous left off.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].we, tbl[i].ad, tbl[i].wd, tbl[i].ce, tbl[i].ca, tbl[i].ra, tbl[i].ra, tbl[i].ra2);
      #1;
      chk($sformatf("vec%0d rd_data0", i), port_data(0), tbl[i].d0);
      chk($sformatf("vec%0d rd_data1", i), port_data(1), tbl[i].d0);
      chk($sformatf("vec%0d rd_busy0", i), 32'(rf_if.rd_busy[0]), 32'(tbl[i].b0));
      chk($sformatf("vec%0d rd_data2", i), port_data(2), tbl[i].d2);
      chk($sformatf("vec%0d claim_ok", i), 32'(rf_if.claim_ok), 32'(tbl[i].ok));
      @(posedge clk); #1;
      chk($sformatf("vec%0d busy_cnt", i), 32'(rf_if.busy_cnt), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d a0", i), rf_if.a0, tbl[i].a0);
    end

    // Reset mid-operation: x7 still claimed, x5/x10 hold data.
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd5, 5'd7, 5'd10);
    #1;
    chk("pre-reset rd_busy x7", 32'(rf_if.rd_busy[1]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset rd_data x5", port_data(0), 32'h0);
    chk("async reset rd_busy x7", 32'(rf_if.rd_busy[1]), 32'd0);
    chk("async reset rd_data x10", port_data(2), 32'h0);
    chk("async reset busy_cnt", 32'(rf_if.busy_cnt), 32'd0);
    chk("async reset a0", rf_if.a0, 32'h0);
    chk("async reset claim_ok", 32'(rf_if.claim_ok), 32'd1);
    @(posedge clk); #1;
    drive(1'b1, 5'd10, 32'hCAFE, 1'b1, 5'd4, 5'd10, 5'd4, 5'd0);
    @(posedge clk); #1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd4, 5'd0);
    #1;
    chk("in-reset write ignored", port_data(0), 32'h0);
    chk("in-reset claim ignored", 32'(rf_if.rd_busy[1]), 32'd0);
    chk("in-reset busy_cnt", 32'(rf_if.busy_cnt), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset a0", rf_if.a0, 32'h0);

    for (int r = 0; r < 32; r++) begin
      mdl_reg[r]  = '0;
      mdl_busy[r] = 1'b0;
    end

    // Random traffic against a rules-level model.
    for (int n = 0; n < 600; n++) begin
      logic        we, ce, ok;
      logic [4:0]  ad, ca;
      logic [4:0]  ra[NR];
      logic [31:0] wd, ed;
      bit          eb;
      int          cnt;
      we = 1'($urandom_range(0, 1));
      ce = 1'($urandom_range(0, 1));
      ad = 5'($urandom_range(0, 15));
      ca = 5'($urandom_range(0, 15));
      wd = $urandom;
      for (int p = 0; p < NR; p++) ra[p] = 5'($urandom_range(0, 15));
      drive(we, ad, wd, ce, ca, ra[0], ra[1], ra[2]);
      #1;
      for (int p = 0; p < NR; p++) begin
        if (ra[p] == 0) begin
          ed = 0; eb = 0;
        end else if (we && ad == ra[p]) begin
          ed = wd; eb = 0;
        end else begin
          ed = mdl_reg[ra[p]]; eb = mdl_busy[ra[p]];
        end
        chk($sformatf("rnd%0d rd_data%0d", n, p), port_data(p), ed);
        chk($sformatf("rnd%0d rd_busy%0d", n, p), 32'(rf_if.rd_busy[p]), 32'(eb));
      end
      ok = !mdl_busy[ca] || (we && ad == ca);
      chk($sformatf("rnd%0d claim_ok", n), 32'(rf_if.claim_ok), 32'(ok));
      @(posedge clk); #1;
      if (we && ad != 0) begin
        mdl_reg[ad]  = wd;
        mdl_busy[ad] = 1'b0;
      end
      if (ce && ok && ca != 0) mdl_busy[ca] = 1'b1;
      cnt = 0;
      for (int r = 0; r < 32; r++) cnt += int'(mdl_busy[r]);
      chk($sformatf("rnd%0d busy_cnt", n), 32'(rf_if.busy_cnt), 32'(cnt));
      chk($sformatf("rnd%0d a0", n), rf_if.a0, mdl_reg[10]);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
